machine_ctl: RTL and testbench

- Instruction-cycle sequencer for the RISC CPU.
- Steps an 8-state machine cycle per instruction, gated by the fetch enable derived from the clock generator.
- Decodes the 3-bit opcode and produces every datapath strobe: PC increment/load, accumulator load, IR load, memory rd/wr, data-bus drive, halt.
- Sits between the clock/reset generator and the datapath: PC, IR, ALU/ACC, data-bus controller.

---
 rtl/risc_pkg.sv | 34 +++
 rtl/machine_ctl_decode.sv | 47 ++++
 rtl/machine_ctl.sv | 94 +++++++++
 tb/tb_machine_ctl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared RISC CPU definitions: opcode encoding, machine-cycle state encoding,
// datapath strobe bundle and ALU-opcode classification.
package risc_pkg;

  localparam logic [2:0] HLT  = 3'b000;
  localparam logic [2:0] SKZ  = 3'b001;
  localparam logic [2:0] ADD  = 3'b010;
  localparam logic [2:0] ANDD = 3'b011;
  localparam logic [2:0] XORR = 3'b100;
  localparam logic [2:0] LDA  = 3'b101;
  localparam logic [2:0] STO  = 3'b110;
  localparam logic [2:0] JMP  = 3'b111;

  typedef enum logic [3:0] {
    S0 = 4'd0, S1 = 4'd1, S2 = 4'd2, S3 = 4'd3,
    S4 = 4'd4, S5 = 4'd5, S6 = 4'd6, S7 = 4'd7,
    HALTED = 4'd8
  } state_t;

  typedef struct packed {
    logic inc_pc;
    logic load_pc;
    logic load_acc;
    logic load_ir;
    logic rd;
    logic wr;
    logic datactl_ena;
  } ctl_t;

  function automatic logic is_aluop(input logic [2:0] op);
    return (op == ADD) || (op == ANDD) || (op == XORR) || (op == LDA);
  endfunction

endpackage

// File: rtl/machine_ctl_decode.sv
// Combinational strobe row for the machine-cycle state about to be entered.
module machine_ctl_decode
  import risc_pkg::*;
(
  input  state_t     st,
  input  logic [2:0] opcode,
  input  logic       zero,
  output ctl_t       row
);

  logic alu, skz_z, jmp, sto;

  always_comb begin
    alu   = is_aluop(opcode);
    skz_z = (opcode == SKZ) && zero;
    jmp   = (opcode == JMP);
    sto   = (opcode == STO);
    row   = '0;
    case (st)
      S0: begin row.rd = 1'b1; row.load_ir = 1'b1; end
      S1: begin row.rd = 1'b1; row.load_ir = 1'b1; row.inc_pc = 1'b1; end
      S3: row.inc_pc = 1'b1;
      S4: begin
        row.rd          = alu;
        row.inc_pc      = skz_z;
        row.load_pc     = jmp;
        row.datactl_ena = sto;
      end
      S5: begin
        row.rd          = alu;
        row.load_acc    = alu;
        row.inc_pc      = skz_z | jmp;
        row.load_pc     = jmp;
        row.wr          = sto;
        row.datactl_ena = sto;
      end
      S6: begin
        row.rd          = alu;
        row.datactl_ena = sto;
      end
      S7: row.inc_pc = skz_z;
      // S2, HALTED and any illegal encoding drive no strobes
      default: row = '0;
    endcase
  end

endmodule

// File: rtl/machine_ctl.sv
// RISC instruction-cycle sequencer: 8-state machine cycle with registered strobes.
// Optional retired-instruction counter output enabled by MACHINE_ICOUNT_EN.
module machine_ctl
  import risc_pkg::*;
#(
  parameter int OPW    = 3,
  parameter int ICNT_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  output logic           inc_pc,
  output logic           load_pc,
  output logic           load_acc,
  output logic           load_ir,
  output logic           rd,
  output logic           wr,
  output logic           datactl_ena,
  output logic           halt
`ifdef MACHINE_ICOUNT_EN
  ,
  output logic [ICNT_W-1:0] icount
`endif
);

  state_t state, nxt;
  logic   run;   // 0 after reset or an ena=0 edge: next ena=1 edge enters S0
  ctl_t   ctl, row;

  always_comb begin
    nxt = S0;
    if (run) begin
      case (state)
        S0:      nxt = S1;
        S1:      nxt = S2;
        S2:      nxt = S3;
        S3:      nxt = (opcode == HLT) ? HALTED : S4;
        S4:      nxt = S5;
        S5:      nxt = S6;
        S6:      nxt = S7;
        S7:      nxt = S0;
        HALTED:  nxt = HALTED;
        default: nxt = S0;
      endcase
    end
  end

  machine_ctl_decode u_dec (
    .st     (nxt),
    .opcode (opcode),
    .zero   (zero),
    .row    (row)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S0;
      run   <= 1'b0;
      ctl   <= '0;
      halt  <= 1'b0;
    end else if (state == HALTED) begin
      ctl  <= '0;
      halt <= 1'b1;
    end else if (!ena) begin
      state <= S0;
      run   <= 1'b0;
      ctl   <= '0;
    end else begin
      state <= nxt;
      run   <= 1'b1;
      ctl   <= row;
      if (nxt == HALTED) halt <= 1'b1;
    end
  end

  assign inc_pc      = ctl.inc_pc;
  assign load_pc     = ctl.load_pc;
  assign load_acc    = ctl.load_acc;
  assign load_ir     = ctl.load_ir;
  assign rd          = ctl.rd;
  assign wr          = ctl.wr;
  assign datactl_ena = ctl.datactl_ena;

`ifdef MACHINE_ICOUNT_EN
  // Only a completed S7 -> S0 step retires an instruction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            icount <= '0;
    else if (ena && run && state == S7)  icount <= icount + 1'b1;
  end
`endif

endmodule

// File: tb/tb_machine_ctl.sv
// Directed table-driven bench for machine_ctl plus hand sequences for
// async reset out of HALTED and the optional instruction counter.
module tb_machine_ctl;
  import risc_pkg::*;

  logic clk = 1'b0, rst = 1'b0, ena = 1'b0, zero = 1'b0;
  logic [2:0] opcode = ADD;
  logic inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt;
`ifdef MACHINE_ICOUNT_EN
  logic [15:0] icount;
`endif

  machine_ctl dut (
    .clk(clk), .rst(rst), .ena(ena), .opcode(opcode), .zero(zero),
    .inc_pc(inc_pc), .load_pc(load_pc), .load_acc(load_acc), .load_ir(load_ir),
    .rd(rd), .wr(wr), .datactl_ena(datactl_ena), .halt(halt)
`ifdef MACHINE_ICOUNT_EN
    , .icount(icount)
`endif
  );

  always #5 clk = ~clk;

  // expected bit order: {inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt}
  localparam logic [7:0] R_S0 = 8'b0001_1000;
  localparam logic [7:0] R_S1 = 8'b1001_1000;
  localparam logic [7:0] R_S3 = 8'b1000_0000;
  localparam logic [7:0] R_0  = 8'b0000_0000;
  localparam logic [7:0] R_H  = 8'b0000_0001;

  typedef struct {
    logic       e;
    logic [2:0] op;
    logic       z;
    logic [7:0] x;
  } vec_t;

  vec_t vecs[$];
  int   nvec = 0, nerr = 0;

  function automatic logic [7:0] outs();
    return {inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt};
  endfunction

  task automatic add(input logic e, input logic [2:0] op, input logic z, input logic [7:0] x);
    vec_t v;
    v.e = e; v.op = op; v.z = z; v.x = x;
    vecs.push_back(v);
  endtask

  task automatic add_instr(input logic [2:0] op, input logic z,
                           input logic [7:0] r4, r5, r6, r7);
    add(1'b1, op, z, R_S0); add(1'b1, op, z, R_S1);
    add(1'b1, op, z, R_0);  add(1'b1, op, z, R_S3);
    add(1'b1, op, z, r4);   add(1'b1, op, z, r5);
    add(1'b1, op, z, r6);   add(1'b1, op, z, r7);
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // ADD, STO, SKZ z=1, SKZ z=0, JMP
    add_instr(ADD, 1'b0, 8'b0000_1000, 8'b0010_1000, 8'b0000_1000, R_0);
    add_instr(STO, 1'b0, 8'b0000_0010, 8'b0000_0110, 8'b0000_0010, R_0);
    add_instr(SKZ, 1'b1, 8'b1000_0000, 8'b1000_0000, R_0, 8'b1000_0000);
    add_instr(SKZ, 1'b0, R_0, R_0, R_0, R_0);
    add_instr(JMP, 1'b0, 8'b0100_0000, 8'b1100_0000, R_0, R_0);
    // ADD aborted in S5, then a clean restart of the ADD
    add(1'b1, ADD, 1'b0, R_S0); add(1'b1, ADD, 1'b0, R_S1);
    add(1'b1, ADD, 1'b0, R_0);  add(1'b1, ADD, 1'b0, R_S3);
    add(1'b1, ADD, 1'b0, 8'b0000_1000); add(1'b1, ADD, 1'b0, 8'b0010_1000);
    add(1'b0, ADD, 1'b0, R_0);  add(1'b0, ADD, 1'b0, R_0);
    add_instr(ADD, 1'b0, 8'b0000_1000, 8'b0010_1000, 8'b0000_1000, R_0);
    // HLT: sticky regardless of ena or opcode
    add(1'b1, HLT, 1'b0, R_S0); add(1'b1, HLT, 1'b0, R_S1);
    add(1'b1, HLT, 1'b0, R_0);  add(1'b1, HLT, 1'b0, R_S3);
    for (int k = 0; k < 8; k++) add(1'b1, HLT, 1'b0, R_H);
    for (int k = 0; k < 6; k++) add(1'b0, ADD, 1'b1, R_H);
    for (int k = 0; k < 8; k++) add(1'b1, JMP, 1'b0, R_H);

    // reset state
    cycles(2);
    check("reset_outputs", {8'h00, outs()}, {8'h00, R_0});
`ifdef MACHINE_ICOUNT_EN
    check("reset_icount", icount, 16'h0000);
`endif
    @(negedge clk) rst = 1'b1;

    foreach (vecs[i]) begin
      ena = vecs[i].e; opcode = vecs[i].op; zero = vecs[i].z;
      @(posedge clk); #1;
      nvec++;
      if (outs() !== vecs[i].x) begin
        nerr++;
        $display("FAIL vec%0d: got %b expected %b", i, outs(), vecs[i].x);
      end
      if ((rd && wr) || (load_pc && load_ir)) begin
        nerr++;
        $display("FAIL invariant vec%0d: rd=%b wr=%b load_pc=%b load_ir=%b",
                 i, rd, wr, load_pc, load_ir);
      end
    end
`ifdef MACHINE_ICOUNT_EN
    check("icount_before_halt", icount, 16'd6);
`endif

    // async reset mid-cycle clears halt without waiting for an edge
    #2 rst = 1'b0;
    #1 check("async_reset_outputs", {8'h00, outs()}, {8'h00, R_0});
    ena = 1'b1; opcode = ADD; zero = 1'b0;
    @(negedge clk) rst = 1'b1;
    cycles(1);
    check("restart_s0", {8'h00, outs()}, {8'h00, R_S0});
    cycles(1);
    check("restart_s1", {8'h00, outs()}, {8'h00, R_S1});

`ifdef MACHINE_ICOUNT_EN
    check("icount_after_reset", icount, 16'h0000);
    cycles(23);  // S0 of the 4th ADD: three retired
    check("icount_three_adds", icount, 16'd3);
    cycles(5);   // now in S5
    ena = 1'b0;
    cycles(1);
    check("icount_abort", icount, 16'd3);
    check("abort_no_load_acc", {15'h0, load_acc}, 16'h0);
    ena = 1'b1;
    cycles(1);
    check("abort_restart_s0", {8'h00, outs()}, {8'h00, R_S0});
    dut.icount = 16'hFFFF;
    cycles(8);
    check("icount_wrap", icount, 16'h0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
